// File: rtl/paddle_controller.sv
// paddle_controller
//   Turns single-cycle up/down step pulses into a clamped vertical paddle
//   position. Steps collect in a saturating signed pending counter and are
//   applied once per frame on frame_tick, so paddle_y is stable across the
//   visible frame.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   up / down  : one-cycle step pulses (toward y=0 / toward y=YMAX)
//   frame_tick : one-cycle pulse at start of vertical blanking
//   recenter   : return paddle to center (priority over frame_tick)
//   enable     : 1 = track input, 0 = paddle frozen
//   paddle_y   : top edge of paddle, 0 .. YMAX
//   moving     : one-cycle pulse when the last update changed paddle_y
//   at_top     : paddle_y == 0
//   at_bottom  : paddle_y == YMAX
module paddle_controller #(
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned PADDLE_HEIGHT = 64,
  parameter int unsigned STEP          = 8,
  parameter int unsigned MAX_PENDING   = 7,
  parameter int unsigned POS_WIDTH     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 frame_tick,
  input  logic                 recenter,
  input  logic                 enable,
  output logic [POS_WIDTH-1:0] paddle_y,
  output logic                 moving,
  output logic                 at_top,
  output logic                 at_bottom
);

  localparam int unsigned YMAX   = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int unsigned CENTER = YMAX / 2;

  // Pending counter: sign bit plus enough magnitude bits for MAX_PENDING.
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1) + 1;
  // Position arithmetic: headroom for the signed step product and overshoot.
  localparam int unsigned CALC_W = POS_WIDTH + PEND_W + $clog2(STEP + 1) + 1;

  localparam logic [POS_WIDTH-1:0]     YMAX_Y   = POS_WIDTH'(YMAX);
  localparam logic [POS_WIDTH-1:0]     CENTER_Y = POS_WIDTH'(CENTER);
  localparam logic signed [CALC_W-1:0] YMAX_S   = CALC_W'(YMAX);
  localparam logic signed [CALC_W-1:0] STEP_S   = CALC_W'(STEP);
  localparam logic signed [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic signed [PEND_W-1:0] PEND_MIN = -PEND_MAX;
  localparam logic                     CENTER_AT_TOP = (CENTER == 0);
  localparam logic                     CENTER_AT_BOT = (CENTER == YMAX);

  logic signed [PEND_W-1:0] pending;
  logic signed [PEND_W-1:0] ev_c;
  logic signed [PEND_W-1:0] pend_acc_c;
  logic signed [CALC_W-1:0] sum_c;
  logic [POS_WIDTH-1:0]     new_y_c;

  // Per-cycle step event, saturating accumulation and clamped frame target.
  always_comb begin
    ev_c       = '0;
    pend_acc_c = pending;
    sum_c      = '0;
    new_y_c    = paddle_y;

    if (down && !up) begin
      ev_c = PEND_W'(1);
    end else if (up && !down) begin
      ev_c = '1;
    end

    if ((ev_c > 0 && pending != PEND_MAX) || (ev_c < 0 && pending != PEND_MIN)) begin
      pend_acc_c = pending + ev_c;
    end

    sum_c = $signed({{(CALC_W - POS_WIDTH){1'b0}}, paddle_y}) + CALC_W'(pending) * STEP_S;

    if (sum_c[CALC_W-1]) begin
      new_y_c = '0;
    end else if (sum_c > YMAX_S) begin
      new_y_c = YMAX_Y;
    end else begin
      new_y_c = POS_WIDTH'(sum_c);
    end
  end

  // Position, pending counter and flags. Recenter wins over frame_tick;
  // a pulse coincident with frame_tick seeds the next frame's pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddle_y  <= CENTER_Y;
      pending   <= '0;
      moving    <= 1'b0;
      at_top    <= CENTER_AT_TOP;
      at_bottom <= CENTER_AT_BOT;
    end else begin
      moving <= 1'b0;
      if (recenter) begin
        paddle_y  <= CENTER_Y;
        pending   <= '0;
        moving    <= (paddle_y != CENTER_Y);
        at_top    <= CENTER_AT_TOP;
        at_bottom <= CENTER_AT_BOT;
      end else if (!enable) begin
        pending <= '0;
      end else if (frame_tick) begin
        paddle_y  <= new_y_c;
        pending   <= ev_c;
        moving    <= (new_y_c != paddle_y);
        at_top    <= (new_y_c == '0);
        at_bottom <= (new_y_c == YMAX_Y);
      end else begin
        pending <= pend_acc_c;
      end
    end
  end

endmodule

// File: tb/tb_paddle_controller.sv
// Directed, table-driven bench for paddle_controller at default parameters.
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       up, down, frame_tick, recenter, enable;
  logic [9:0] paddle_y;
  logic       moving, at_top, at_bottom;

  int n_chk  = 0;
  int n_fail = 0;

  paddle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .up         (up),
    .down       (down),
    .frame_tick (frame_tick),
    .recenter   (recenter),
    .enable     (enable),
    .paddle_y   (paddle_y),
    .moving     (moving),
    .at_top     (at_top),
    .at_bottom  (at_bottom)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    nu;   // up pulses
    int    nd;   // down pulses
    int    nb;   // cycles with up and down together
    bit    td;   // down coincident with the final cycle
    bit    ft;   // frame_tick on final cycle
    bit    rc;   // recenter on final cycle
    bit    en;   // enable for the whole vector
    int    y;
    bit    mv;
    bit    top;
    bit    bot;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, int nu, int nd, int nb, bit td, bit ft,
                              bit rc, bit en, int y, bit mv, bit top, bit bot);
    vec_t v;
    v.name = name; v.nu = nu; v.nd = nd; v.nb = nb; v.td = td; v.ft = ft;
    v.rc = rc; v.en = en; v.y = y; v.mv = mv; v.top = top; v.bot = bot;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int y, input bit mv, input bit top, input bit bot);
    chk({name, ".paddle_y"}, int'(paddle_y), y);
    chk({name, ".moving"}, int'(moving), int'(mv));
    chk({name, ".at_top"}, int'(at_top), int'(top));
    chk({name, ".at_bottom"}, int'(at_bottom), int'(bot));
  endtask

  // One clock: drive at negedge, return 1 time unit after the rising edge.
  task automatic cyc(input bit u, input bit d, input bit ft, input bit rc, input bit en);
    @(negedge clk);
    up = u; down = d; frame_tick = ft; recenter = rc; enable = en;
    @(posedge clk);
    #1;
    up = 1'b0; down = 1'b0; frame_tick = 1'b0; recenter = 1'b0;
  endtask

  initial begin
    up = 0; down = 0; frame_tick = 0; recenter = 0; enable = 1;
    reset = 1'b1;

    // name        nu nd nb td ft rc en   y   mv top bot
    add("up3",       3, 0, 0, 0, 1, 0, 1, 184, 1, 0, 0);
    add("idle_ft",   0, 0, 0, 0, 1, 0, 1, 184, 0, 0, 0);
    add("recenter",  0, 0, 0, 0, 0, 1, 1, 208, 1, 0, 0);
    add("sat_down",  0,10, 0, 0, 1, 0, 1, 264, 1, 0, 0);
    add("both",      0, 0, 3, 0, 1, 0, 1, 264, 0, 0, 0);
    add("down7a",    0, 7, 0, 0, 1, 0, 1, 320, 1, 0, 0);
    add("down7b",    0, 7, 0, 0, 1, 0, 1, 376, 1, 0, 0);
    add("down3",     0, 3, 0, 0, 1, 0, 1, 400, 1, 0, 0);
    add("clamp_bot", 0, 5, 0, 0, 1, 0, 1, 416, 1, 0, 1);
    add("push_bot",  0, 5, 0, 0, 1, 0, 1, 416, 0, 0, 1);
    add("up7_1",     7, 0, 0, 0, 1, 0, 1, 360, 1, 0, 0);
    add("up7_2",     7, 0, 0, 0, 1, 0, 1, 304, 1, 0, 0);
    add("up7_3",     7, 0, 0, 0, 1, 0, 1, 248, 1, 0, 0);
    add("up7_4",     7, 0, 0, 0, 1, 0, 1, 192, 1, 0, 0);
    add("up7_5",     7, 0, 0, 0, 1, 0, 1, 136, 1, 0, 0);
    add("up7_6",     7, 0, 0, 0, 1, 0, 1,  80, 1, 0, 0);
    add("up7_7",     7, 0, 0, 0, 1, 0, 1,  24, 1, 0, 0);
    add("up2a",      2, 0, 0, 0, 1, 0, 1,   8, 1, 0, 0);
    add("clamp_top", 2, 0, 0, 0, 1, 0, 1,   0, 1, 1, 0);
    add("push_top",  3, 0, 0, 0, 1, 0, 1,   0, 0, 1, 0);
    add("rc2",       0, 0, 0, 0, 0, 1, 1, 208, 1, 0, 0);
    add("coincide",  0, 2, 0, 1, 1, 0, 1, 224, 1, 0, 0);
    add("carry",     0, 0, 0, 0, 1, 0, 1, 232, 1, 0, 0);
    add("up7c",      7, 0, 0, 0, 1, 0, 1, 176, 1, 0, 0);
    add("up7d",      7, 0, 0, 0, 1, 0, 1, 120, 1, 0, 0);
    add("up2b",      2, 0, 0, 0, 1, 0, 1, 104, 1, 0, 0);
    add("rc_prio",   5, 0, 0, 0, 1, 1, 1, 208, 1, 0, 0);
    add("after_rc",  0, 0, 0, 0, 1, 0, 1, 208, 0, 0, 0);
    add("down3b",    0, 3, 0, 0, 1, 0, 1, 232, 1, 0, 0);
    add("frz_pulse", 4, 0, 0, 0, 1, 0, 0, 232, 0, 0, 0);
    add("frz_rc",    0, 0, 0, 0, 0, 1, 0, 208, 1, 0, 0);
    add("frz_down",  0, 4, 0, 0, 1, 0, 0, 208, 0, 0, 0);
    add("thaw_ft",   0, 0, 0, 0, 1, 0, 1, 208, 0, 0, 0);
    add("sat_up",   10, 0, 0, 0, 1, 0, 1, 152, 1, 0, 0);

    // Reset state while asserted
    #2;
    chk_all("reset_init", 208, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].nu; k++) cyc(1, 0, 0, 0, vecs[i].en);
      for (int k = 0; k < vecs[i].nd; k++) cyc(0, 1, 0, 0, vecs[i].en);
      for (int k = 0; k < vecs[i].nb; k++) cyc(1, 1, 0, 0, vecs[i].en);
      cyc(0, vecs[i].td, vecs[i].ft, vecs[i].rc, vecs[i].en);
      chk_all(vecs[i].name, vecs[i].y, vecs[i].mv, vecs[i].top, vecs[i].bot);
    end

    // moving lasts exactly one cycle; position holds without frame_tick
    cyc(0, 0, 0, 0, 1);
    chk_all("mv_one_cycle", 152, 0, 0, 0);

    // Asynchronous reset mid-frame discards pending steps
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 208, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk_all("post_reset_ft", 216, 1, 0, 0);

    // Back-to-back frame ticks: second applies an empty pending counter
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk_all("b2b_first", 200, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk_all("b2b_second", 200, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
